// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, ALU codes, state/step encoding and control bundle for control_unit.
// Rev 1.0
`default_nettype none
package cu_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  localparam logic [3:0] STEP_WAIT = 4'd8;
  localparam logic [3:0] STEP_IDLE = 4'd14;
  localparam logic [3:0] STEP_HALT = 4'd15;

  // State codes double as the externally visible step index.
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_WAIT = STEP_WAIT, S_IDLE = STEP_IDLE, S_HALT = STEP_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALU_R, CL_ALU_I, CL_NOP, CL_HALT, CL_ILL
  } iclass_t;

  typedef enum logic [1:0] {RET_T2, RET_T7, RET_END} ret_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic z_in;
    logic zlow_out;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic c_out;
    logic ba_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ram_read;
    logic ram_write;
    logic md_read;
  } ctrl_t;
endpackage
`default_nettype wire

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode -> instruction class and ALU operation.
// Rev 1.0
`default_nettype none
module cu_decode
  import cu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_t    class_o,
  output logic [4:0] alu_op_o
);
  always_comb begin
    class_o  = CL_ILL;
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OP_LD:   class_o = CL_LD;
      OP_LDI:  class_o = CL_LDI;
      OP_ST:   class_o = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        class_o  = CL_ALU_R;
        alu_op_o = opcode_i;
      end
      OP_ADDI: class_o = CL_ALU_I;
      OP_ANDI: begin
        class_o  = CL_ALU_I;
        alu_op_o = ALU_AND;
      end
      OP_ORI: begin
        class_o  = CL_ALU_I;
        alu_op_o = ALU_OR;
      end
      OP_NOP:  class_o = CL_NOP;
      OP_HALT: class_o = CL_HALT;
      default: class_o = CL_ILL;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer for the single-bus DataPath.
// Rev 1.0
`default_nettype none
module control_unit
  import cu_pkg::*;
#(
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] instruction,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Cout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        ram_read,
  output logic        ram_write,
  output logic        MD_read,
  output logic [4:0]  alu_op,
  output logic        running,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  step
);
  localparam logic       HAS_WAIT    = (MEM_LAT > 1);
  localparam logic [2:0] WAIT_CYCLES = 3'(MEM_LAT - 1);

  state_t     state_q, state_d, w_end;
  ret_t       ret_q, ret_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_q, wr_d, halted_q, halted_d, illegal_q, illegal_d;
  iclass_t    w_cls;
  logic [4:0] w_alu;
  ctrl_t      w_ctrl;
  logic       w_unused_bits;

  assign w_unused_bits = ^{instruction[26:0], PC_RESET};

  cu_decode u_decode (
    .opcode_i (instruction[31:27]),
    .class_o  (w_cls),
    .alu_op_o (w_alu)
  );

  always_comb begin
    w_end     = run ? S_T0 : S_IDLE;
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (HAS_WAIT) begin
          state_d = S_WAIT; cnt_d = WAIT_CYCLES; ret_d = RET_T2; wr_d = 1'b0;
        end else state_d = S_T2;
      end
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (w_cls)
          CL_NOP:  state_d = w_end;
          CL_HALT: begin state_d = S_HALT; halted_d = 1'b1; end
          CL_ILL:  begin state_d = S_HALT; illegal_d = 1'b1; end
          default: state_d = S_T4;
        endcase
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (w_cls == CL_LD || w_cls == CL_ST) ? S_T6 : w_end;
      S_T6: begin
        if (w_cls == CL_LD && HAS_WAIT) begin
          state_d = S_WAIT; cnt_d = WAIT_CYCLES; ret_d = RET_T7; wr_d = 1'b0;
        end else state_d = S_T7;
      end
      S_T7: begin
        if (w_cls == CL_ST && HAS_WAIT) begin
          state_d = S_WAIT; cnt_d = WAIT_CYCLES; ret_d = RET_END; wr_d = 1'b1;
        end else state_d = w_end;
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          case (ret_q)
            RET_T2:  state_d = S_T2;
            RET_T7:  state_d = S_T7;
            default: state_d = w_end;
          endcase
        end else cnt_d = cnt_q - 3'd1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      ret_q     <= RET_T2;
      cnt_q     <= 3'd0;
      wr_q      <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Execute steps read IR directly; it is stable from T3 until the next T2.
  always_comb begin
    w_ctrl = '0;
    alu_op = ALU_ADD;
    case (state_q)
      S_T0: begin
        w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1; w_ctrl.inc_pc = 1'b1; w_ctrl.z_in = 1'b1;
      end
      S_T1: begin
        w_ctrl.zlow_out = 1'b1; w_ctrl.pc_in = 1'b1;
        w_ctrl.ram_read = 1'b1; w_ctrl.md_read = 1'b1; w_ctrl.mdr_in = 1'b1;
      end
      S_WAIT: begin
        if (wr_q) w_ctrl.ram_write = 1'b1;
        else begin
          w_ctrl.ram_read = 1'b1; w_ctrl.md_read = 1'b1; w_ctrl.mdr_in = 1'b1;
        end
      end
      S_T2: begin w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1; end
      S_T3: begin
        if (w_cls == CL_LD || w_cls == CL_LDI || w_cls == CL_ST) begin
          w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1;
        end else if (w_cls == CL_ALU_R || w_cls == CL_ALU_I) begin
          w_ctrl.grb = 1'b1; w_ctrl.r_out = 1'b1; w_ctrl.y_in = 1'b1;
        end
      end
      S_T4: begin
        w_ctrl.z_in = 1'b1;
        if (w_cls == CL_ALU_R) begin w_ctrl.grc = 1'b1; w_ctrl.r_out = 1'b1; end
        else w_ctrl.c_out = 1'b1;
        if (w_cls == CL_ALU_R || w_cls == CL_ALU_I) alu_op = w_alu;
      end
      S_T5: begin
        w_ctrl.zlow_out = 1'b1;
        if (w_cls == CL_LD || w_cls == CL_ST) w_ctrl.mar_in = 1'b1;
        else begin w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
      end
      S_T6: begin
        w_ctrl.mdr_in = 1'b1;
        if (w_cls == CL_ST) begin w_ctrl.gra = 1'b1; w_ctrl.r_out = 1'b1; end
        else begin w_ctrl.ram_read = 1'b1; w_ctrl.md_read = 1'b1; end
      end
      S_T7: begin
        if (w_cls == CL_ST) w_ctrl.ram_write = 1'b1;
        else begin w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.r_in = 1'b1; end
      end
      default: w_ctrl = '0;
    endcase
  end

  assign PCout     = w_ctrl.pc_out;
  assign MARin     = w_ctrl.mar_in;
  assign IncPC     = w_ctrl.inc_pc;
  assign PCin      = w_ctrl.pc_in;
  assign Zin       = w_ctrl.z_in;
  assign Zlowout   = w_ctrl.zlow_out;
  assign MDRin     = w_ctrl.mdr_in;
  assign MDRout    = w_ctrl.mdr_out;
  assign IRin      = w_ctrl.ir_in;
  assign Yin       = w_ctrl.y_in;
  assign Cout      = w_ctrl.c_out;
  assign BAout     = w_ctrl.ba_out;
  assign Gra       = w_ctrl.gra;
  assign Grb       = w_ctrl.grb;
  assign Grc       = w_ctrl.grc;
  assign Rin       = w_ctrl.r_in;
  assign Rout      = w_ctrl.r_out;
  assign ram_read  = w_ctrl.ram_read;
  assign ram_write = w_ctrl.ram_write;
  assign MD_read   = w_ctrl.md_read;
  assign running   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign step      = state_q;
endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench, one instance at MEM_LAT=1 and one at MEM_LAT=3.
// Rev 1.0
`default_nettype none
module tb_control_unit;
  localparam logic [19:0] PCOUT = 20'h80000, MARIN = 20'h40000, INCPC = 20'h20000, PCIN = 20'h10000;
  localparam logic [19:0] ZIN = 20'h08000, ZLOW = 20'h04000, MDRIN = 20'h02000, MDROUT = 20'h01000;
  localparam logic [19:0] IRIN = 20'h00800, YIN = 20'h00400, COUT = 20'h00200, BAOUT = 20'h00100;
  localparam logic [19:0] GRA = 20'h00080, GRB = 20'h00040, GRC = 20'h00020, RIN = 20'h00010;
  localparam logic [19:0] ROUT = 20'h00008, RRD = 20'h00004, RWR = 20'h00002, MDRD = 20'h00001;
  localparam logic [4:0]  ADD = 5'b00011;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  logic        clock = 1'b0, clear = 1'b0, run1 = 1'b0, run3 = 1'b0;
  logic [31:0] fetch1 = '0, fetch3 = '0, ir1 = '0, ir3 = '0;
  logic [19:0] c1, c3;
  logic [4:0]  alu1, alu3;
  logic [3:0]  st1, st3;
  logic        rn1, rn3, hl1, hl3, il1, il3;
  logic [31:0] obs1, obs3;
  exp_t        sb[$];
  int          vectors = 0, miscompares = 0;

  always #5 clock = ~clock;

  control_unit #(.MEM_LAT(1), .PC_RESET(32'h0)) u_dut1 (
    .clock(clock), .clear(clear), .run(run1), .instruction(ir1),
    .PCout(c1[19]), .MARin(c1[18]), .IncPC(c1[17]), .PCin(c1[16]), .Zin(c1[15]),
    .Zlowout(c1[14]), .MDRin(c1[13]), .MDRout(c1[12]), .IRin(c1[11]), .Yin(c1[10]),
    .Cout(c1[9]), .BAout(c1[8]), .Gra(c1[7]), .Grb(c1[6]), .Grc(c1[5]), .Rin(c1[4]),
    .Rout(c1[3]), .ram_read(c1[2]), .ram_write(c1[1]), .MD_read(c1[0]),
    .alu_op(alu1), .running(rn1), .halted(hl1), .illegal(il1), .step(st1));

  control_unit #(.MEM_LAT(3), .PC_RESET(32'h0)) u_dut3 (
    .clock(clock), .clear(clear), .run(run3), .instruction(ir3),
    .PCout(c3[19]), .MARin(c3[18]), .IncPC(c3[17]), .PCin(c3[16]), .Zin(c3[15]),
    .Zlowout(c3[14]), .MDRin(c3[13]), .MDRout(c3[12]), .IRin(c3[11]), .Yin(c3[10]),
    .Cout(c3[9]), .BAout(c3[8]), .Gra(c3[7]), .Grb(c3[6]), .Grc(c3[5]), .Rin(c3[4]),
    .Rout(c3[3]), .ram_read(c3[2]), .ram_write(c3[1]), .MD_read(c3[0]),
    .alu_op(alu3), .running(rn3), .halted(hl3), .illegal(il3), .step(st3));

  assign obs1 = {st1, alu1, c1, rn1, hl1, il1};
  assign obs3 = {st3, alu3, c3, rn3, hl3, il3};

  // Stand-in for the DataPath IR: loads the fetched word while IRin is high.
  always @(posedge clock) begin
    if (c1[11]) ir1 <= fetch1;
    if (c3[11]) ir3 <= fetch3;
  end

  task automatic push(input string tag, input logic [3:0] st, input logic [19:0] c,
                      input logic [4:0] alu, input logic h, input logic il);
    exp_t e;
    e.tag = tag;
    e.v   = {st, alu, c, (st <= 4'd8), h, il};
    sb.push_back(e);
  endtask

  task automatic check_one(input bit d3);
    exp_t        e;
    logic [31:0] o;
    e = sb.pop_front();
    o = d3 ? obs3 : obs1;
    vectors++;
    assert (o === e.v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
    end
  endtask

  task automatic drain(input bit d3, input int stop_after);
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_one(d3);
      if (i == stop_after) begin
        if (d3) run3 = 1'b0;
        else    run1 = 1'b0;
      end
    end
  endtask

  task automatic exec(input bit d3, input logic [31:0] instr, input int stop_after);
    int         lat;
    logic [4:0] op;
    lat = d3 ? 3 : 1;
    op  = instr[31:27];
    if (d3) fetch3 = instr;
    else    fetch1 = instr;
    push("T0", 4'd0, PCOUT | MARIN | INCPC | ZIN, ADD, 1'b0, 1'b0);
    push("T1", 4'd1, ZLOW | PCIN | RRD | MDRD | MDRIN, ADD, 1'b0, 1'b0);
    for (int k = 1; k < lat; k++) push("fetch WAIT", 4'd8, RRD | MDRD | MDRIN, ADD, 1'b0, 1'b0);
    push("T2", 4'd2, MDROUT | IRIN, ADD, 1'b0, 1'b0);
    case (op)
      5'b00000, 5'b00001, 5'b00010: begin
        push("mem T3", 4'd3, GRB | BAOUT | YIN, ADD, 1'b0, 1'b0);
        push("mem T4", 4'd4, COUT | ZIN, ADD, 1'b0, 1'b0);
        if (op == 5'b00001) push("ldi T5", 4'd5, ZLOW | GRA | RIN, ADD, 1'b0, 1'b0);
        else push("ld/st T5", 4'd5, ZLOW | MARIN, ADD, 1'b0, 1'b0);
        if (op == 5'b00000) begin
          push("ld T6", 4'd6, RRD | MDRD | MDRIN, ADD, 1'b0, 1'b0);
          for (int k = 1; k < lat; k++) push("ld WAIT", 4'd8, RRD | MDRD | MDRIN, ADD, 1'b0, 1'b0);
          push("ld T7", 4'd7, MDROUT | GRA | RIN, ADD, 1'b0, 1'b0);
        end else if (op == 5'b00010) begin
          push("st T6", 4'd6, GRA | ROUT | MDRIN, ADD, 1'b0, 1'b0);
          push("st T7", 4'd7, RWR, ADD, 1'b0, 1'b0);
          for (int k = 1; k < lat; k++) push("st WAIT", 4'd8, RWR, ADD, 1'b0, 1'b0);
        end
      end
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push("aluR T3", 4'd3, GRB | ROUT | YIN, ADD, 1'b0, 1'b0);
        push("aluR T4", 4'd4, GRC | ROUT | ZIN, op, 1'b0, 1'b0);
        push("aluR T5", 4'd5, ZLOW | GRA | RIN, ADD, 1'b0, 1'b0);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        push("aluI T3", 4'd3, GRB | ROUT | YIN, ADD, 1'b0, 1'b0);
        push("aluI T4", 4'd4, COUT | ZIN,
             (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00101 : 5'b00110, 1'b0, 1'b0);
        push("aluI T5", 4'd5, ZLOW | GRA | RIN, ADD, 1'b0, 1'b0);
      end
      5'b11010: push("nop T3", 4'd3, 20'h0, ADD, 1'b0, 1'b0);
      5'b11011: begin
        push("halt T3", 4'd3, 20'h0, ADD, 1'b0, 1'b0);
        push("halt HALT", 4'd15, 20'h0, ADD, 1'b1, 1'b0);
      end
      default: begin
        push("ill T3", 4'd3, 20'h0, ADD, 1'b0, 1'b0);
        push("ill HALT", 4'd15, 20'h0, ADD, 1'b0, 1'b1);
      end
    endcase
    drain(d3, stop_after);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    push("reset dut1", 4'd14, 20'h0, ADD, 1'b0, 1'b0); check_one(1'b0);
    push("reset dut3", 4'd14, 20'h0, ADD, 1'b0, 1'b0); check_one(1'b1);
    clear = 1'b1;
    push("idle run=0", 4'd14, 20'h0, ADD, 1'b0, 1'b0);
    push("idle run=0", 4'd14, 20'h0, ADD, 1'b0, 1'b0);
    drain(1'b0, -1);

    run1 = 1'b1;
    exec(1'b0, 32'h0900_0054, -1);                                   // ldi R2,0x54(R0)
    exec(1'b0, {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, -1);             // add R1,R2,R3
    exec(1'b0, {5'b00010, 4'd1, 4'd0, 19'h10}, -1);                  // st R1,0x10
    exec(1'b0, {5'b00100, 4'd4, 4'd1, 4'd2, 15'd0}, -1);             // sub
    exec(1'b0, {5'b01101, 4'd5, 4'd1, 19'h0F}, -1);                  // andi
    exec(1'b0, {5'b01100, 4'd5, 4'd5, 19'h01}, -1);                  // addi
    exec(1'b0, {5'b11010, 27'd0}, -1);                               // nop
    exec(1'b0, {5'b00000, 4'd6, 4'd0, 19'h10}, -1);                  // ld R6,0x10
    exec(1'b0, {5'b01110, 4'd7, 4'd6, 19'h30}, 4);                   // ori, run dropped in T4
    push("idle after ori", 4'd14, 20'h0, ADD, 1'b0, 1'b0);
    push("idle hold", 4'd14, 20'h0, ADD, 1'b0, 1'b0);
    drain(1'b0, -1);

    // Async clear while dut1 sits in T4 of an ldi.
    fetch1 = 32'h0900_0054;
    run1 = 1'b1;
    repeat (5) @(negedge clock);
    push("pre-clear T4", 4'd4, COUT | ZIN, ADD, 1'b0, 1'b0); check_one(1'b0);
    clear = 1'b0;
    #1;
    push("clear mid-T4", 4'd14, 20'h0, ADD, 1'b0, 1'b0); check_one(1'b0);
    run1 = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    push("idle after clear", 4'd14, 20'h0, ADD, 1'b0, 1'b0);
    push("idle after clear", 4'd14, 20'h0, ADD, 1'b0, 1'b0);
    drain(1'b0, -1);

    run3 = 1'b1;
    exec(1'b1, {5'b00000, 4'd4, 4'd0, 19'h20}, -1);                  // ld, MEM_LAT=3
    exec(1'b1, {5'b00010, 4'd4, 4'd0, 19'h30}, -1);                  // st, MEM_LAT=3
    exec(1'b1, 32'hF800_0000, -1);                                   // opcode 11111
    for (int k = 0; k < 3; k++) push("ill HALT hold", 4'd15, 20'h0, ADD, 1'b0, 1'b1);
    drain(1'b1, -1);
    run3 = 1'b0;
    clear = 1'b0;
    #1;
    push("clear from HALT", 4'd14, 20'h0, ADD, 1'b0, 1'b0); check_one(1'b1);
    @(negedge clock);
    clear = 1'b1;

    run1 = 1'b1;
    exec(1'b0, {5'b11011, 27'd0}, -1);                               // halt
    for (int k = 0; k < 2; k++) push("halt hold", 4'd15, 20'h0, ADD, 1'b1, 1'b0);
    drain(1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
